// File: rtl/mux_rr_nx1.sv
// Purpose : N-input, W-bit registered mux with fair round-robin arbitration
//           and valid/ready handshakes on every input and on the output.
// Latency : 1 cycle from input handshake to OUT_VALID; 1 word/cycle sustained.
// Backpressure: the one-entry output register loads only when empty or being
//           drained (OUT_READY=1); otherwise every IN_READY bit stays 0.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   IN_DATA/VALID/READY flattened channel words (channel i at [i*W +: W]),
//                       per-channel request and one-hot (or zero) accept
//   OUT_DATA/VALID/READY registered output word and handshake
//   OUT_SEL             channel index of the word held in OUT_DATA
//   FORCE, FORCE_SEL    select override, present only when MUX_FORCE_EN is
//                       defined; the default build is pure round-robin
//
// N must be a power of two (2..32) so the pointer wraps by plain overflow.
module mux_rr_nx1 #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N*W-1:0]       IN_DATA,
  input  logic [N-1:0]         IN_VALID,
  output logic [N-1:0]         IN_READY,
  output logic [W-1:0]         OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [$clog2(N)-1:0] OUT_SEL
`ifdef MUX_FORCE_EN
  ,
  input  logic                 FORCE,
  input  logic [$clog2(N)-1:0] FORCE_SEL
`endif
);

  localparam int SW = $clog2(N);

  logic          out_vld_q, out_vld_d;
  logic [W-1:0]  out_dat_q, out_dat_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          ld;
  logic          rr_hit;
  logic [SW-1:0] rr_gnt;
  logic [SW-1:0] idx;
  logic          hit;
  logic [SW-1:0] gnt;
  logic          adv_ptr;
  logic [W-1:0]  sel_dat;

  // The register can take a new word when empty or when its word leaves now.
  assign ld = !out_vld_q || OUT_READY;

  // First requester at or after ptr, modulo N. Scanning from the far end
  // lets the nearest hit win without needing a break.
  always_comb begin
    rr_hit = 1'b0;
    rr_gnt = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_q + SW'(k);
      if (IN_VALID[idx]) begin
        rr_hit = 1'b1;
        rr_gnt = idx;
      end
    end
  end

`ifdef MUX_FORCE_EN
  // Forced selection bypasses the arbiter and freezes the pointer so that
  // round-robin resumes where it left off once FORCE drops.
  always_comb begin
    if (FORCE) begin
      gnt = FORCE_SEL;
      hit = IN_VALID[FORCE_SEL];
    end else begin
      gnt = rr_gnt;
      hit = rr_hit;
    end
  end
  assign adv_ptr = !FORCE;
`else
  assign gnt     = rr_gnt;
  assign hit     = rr_hit;
  assign adv_ptr = 1'b1;
`endif

  // Data steering only feeds the register, so IN_DATA never reaches an output
  // combinationally.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == gnt) begin
        sel_dat = IN_DATA[i*W +: W];
      end
    end
  end

  always_comb begin
    IN_READY = '0;
    if (ld && hit && !RST) begin
      IN_READY = N'(1) << gnt;
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_sel_d = out_sel_q;
    ptr_d     = ptr_q;
    if (ld) begin
      out_vld_d = hit;
      if (hit) begin
        out_dat_d = sel_dat;
        out_sel_d = gnt;
        if (adv_ptr) begin
          ptr_d = gnt + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_sel_q <= '0;
      ptr_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_sel_q <= out_sel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign OUT_VALID = out_vld_q;
  assign OUT_DATA  = out_dat_q;
  assign OUT_SEL   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
module tb_mux_rr_nx1;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N*W-1:0] IN_DATA = '0;
  logic [N-1:0]   IN_VALID = '0;
  logic [N-1:0]   IN_READY;
  logic [W-1:0]   OUT_DATA;
  logic           OUT_VALID;
  logic           OUT_READY = 1'b0;
  logic [SW-1:0]  OUT_SEL;

  int total = 0;
  int bad   = 0;

  mux_rr_nx1 #(.W(W), .N(N)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_SEL(OUT_SEL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Abstract state: is a word held, which word/channel, and where the
  // round-robin search starts. Checked on every falling edge, then advanced
  // to what the next rising edge must produce.
  logic         m_vld = 1'b0;
  logic [W-1:0] m_dat = '0;
  int           m_sel = 0;
  int           m_ptr = 0;
  int           waitc [N];
  int           g;
  bit           hit;
  bit           load;
  logic [N-1:0] exp_rdy;

  always @(negedge CLK) begin
    hit = 0;
    g   = 0;
    for (int k = 0; k < N; k++) begin
      if (!hit && IN_VALID[(m_ptr + k) % N]) begin
        hit = 1;
        g   = (m_ptr + k) % N;
      end
    end
    load    = !m_vld || OUT_READY;
    exp_rdy = '0;
    if (load && hit && !RST) exp_rdy[g] = 1'b1;

    chk("m_in_ready",  64'(IN_READY),  64'(exp_rdy));
    chk("m_out_valid", 64'(OUT_VALID), 64'(m_vld));
    chk("m_out_data",  64'(OUT_DATA),  64'(m_dat));
    chk("m_out_sel",   64'(OUT_SEL),   64'(m_sel));

    if (RST) begin
      m_vld = 0; m_dat = '0; m_sel = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) if (!IN_VALID[i]) waitc[i] = 0;
      if (load) begin
        if (hit) begin
          // a held request may see at most N-1 other grants before its own
          chk("m_fairness", 64'(waitc[g] <= N - 1), 64'd1);
          for (int i = 0; i < N; i++) begin
            if (i == g) waitc[i] = 0;
            else if (IN_VALID[i]) waitc[i]++;
          end
          m_vld = 1;
          m_dat = IN_DATA[g*W +: W];
          m_sel = g;
          m_ptr = (g + 1) % N;
        end else begin
          m_vld = 0;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  int           rr_seq  [6] = '{0, 1, 2, 3, 0, 1};
  int           alt_seq [3] = '{3, 2, 3};
  logic [N-1:0] hs;
  logic         rst_now;

  initial begin
    for (int i = 0; i < N; i++) waitc[i] = 0;
    repeat (2) tick();
    RST = 1'b0;

    // reset release, no requests
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("idle_vld", 64'(OUT_VALID), 64'd0);
      chk("idle_dat", 64'(OUT_DATA),  64'd0);
      chk("idle_sel", 64'(OUT_SEL),   64'd0);
      chk("idle_rdy", 64'(IN_READY),  64'd0);
    end

    // all channels requesting: strict rotation, no bubbles
    for (int i = 0; i < N; i++) IN_DATA[i*W +: W] = 32'hA0 + 32'(i);
    IN_VALID  = '1;
    OUT_READY = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("rr_vld", 64'(OUT_VALID), 64'd1);
      chk("rr_sel", 64'(OUT_SEL),   64'(rr_seq[j]));
      chk("rr_dat", 64'(OUT_DATA),  64'hA0 + 64'(rr_seq[j]));
    end

    // only channel 2 requesting: accepted every cycle
    IN_VALID = 4'b0100;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("solo_rdy", 64'(IN_READY), 64'b0100);
      tick();
      chk("solo_sel", 64'(OUT_SEL),  64'd2);
      chk("solo_dat", 64'(OUT_DATA), 64'hA2);
    end

    // channels 2 and 3: pointer sits at 3, so 3,2,3
    IN_VALID = 4'b1100;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("alt_sel", 64'(OUT_SEL), 64'(alt_seq[j]));
    end

    // backpressure: hold channel 1's 0x55 while 0 and 3 wait
    IN_VALID = 4'b0010;
    IN_DATA[1*W +: W] = 32'h55;
    tick();
    chk("bp_load_sel", 64'(OUT_SEL),  64'd1);
    chk("bp_load_dat", 64'(OUT_DATA), 64'h55);
    OUT_READY = 1'b0;
    IN_VALID  = 4'b1001;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_rdy", 64'(IN_READY), 64'd0);
      tick();
      chk("bp_vld", 64'(OUT_VALID), 64'd1);
      chk("bp_dat", 64'(OUT_DATA),  64'h55);
      chk("bp_sel", 64'(OUT_SEL),   64'd1);
    end
    OUT_READY = 1'b1;
    #1;
    chk("bp_resume_rdy", 64'(IN_READY), 64'b1000);
    tick();
    chk("bp_resume_sel", 64'(OUT_SEL), 64'd3);
    tick();
    chk("bp_next_sel", 64'(OUT_SEL), 64'd0);

    // reset while full with requests pending; pointer is 1 here
    RST = 1'b1;
    #1;
    chk("rst_rdy", 64'(IN_READY), 64'd0);
    tick();
    chk("rst_vld", 64'(OUT_VALID), 64'd0);
    RST = 1'b0;
    tick();
    chk("rst_first_vld", 64'(OUT_VALID), 64'd1);
    chk("rst_first_sel", 64'(OUT_SEL),   64'd0);

    // random traffic; requests held until their handshake completes
    #1;
    for (int c = 0; c < 3000; c++) begin
      hs      = IN_VALID & IN_READY;
      rst_now = RST;
      tick();
      RST       = ($urandom_range(0, 99) == 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (hs[i] || rst_now || !IN_VALID[i]) begin
          IN_VALID[i]       = ($urandom_range(0, 2) != 0);
          IN_DATA[i*W +: W] = $urandom;
        end
      end
      #1;
    end

    RST = 1'b1;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_nx1.md
# mux_rr_nx1

Parametrised N-input, W-bit registered multiplexer with round-robin arbitration and valid/ready handshakes on every input and on the output. It generalises the fixed-select word muxes of the datapath library to shared-resource steering, for example merging several requesters onto one memory or register-file write path. Channel selection is internal, fair and starvation-free. Output is a one-entry register: latency 1 cycle, throughput 1 word/cycle.

## Interface
- W, default 32: data word width; legal values are 1..64.
- N, default 4: input channel count; must be a power of 2 in the range 2..32.
- SW, derived as log2(N), not overridable: width of the channel index.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous and active-high.
- IN_DATA  in  N*W  flattened channel words; channel i occupies [i*W +: W].
- IN_VALID  in  N  per-channel request.
- IN_READY  out  N  per-channel accept; at most one bit is set.
- OUT_DATA  out  W  registered output word.
- OUT_VALID  out  1  OUT_DATA holds an untaken word.
- OUT_READY  in  1  downstream accept.
- OUT_SEL  out  SW  channel index of the word in OUT_DATA.
- FORCE  in  1  select override enable; present only with MUX_FORCE_EN.
- FORCE_SEL  in  SW  forced channel index; present only with MUX_FORCE_EN.

## Operation
- State elements:
  - output register {OUT_VALID, OUT_DATA, OUT_SEL};
  - round-robin pointer ptr[SW-1:0].
- Two states, encoded by OUT_VALID:
  - EMPTY (0): the register can load.
  - FULL (1): the register loads only if OUT_READY=1 in the same cycle.
- Load enable: ld = !OUT_VALID | OUT_READY. This is combinational.
- Grant selection:
  - g is the first index with IN_VALID set, scanning ptr, ptr+1, … , ptr+N-1, all mod N.
  - hit=0 when no IN_VALID bit is set.
- IN_READY[i] = ld & hit & (i==g) & !RST. It is combinational from IN_VALID, OUT_VALID and OUT_READY.
- A transfer occurs on channel i when IN_VALID[i] & IN_READY[i].
- On a rising edge with ld=1 and hit=1:
  - OUT_DATA <= IN_DATA[g*W +: W], OUT_SEL <= g, OUT_VALID <= 1;
  - ptr <= (g+1) mod N.
- On a rising edge with ld=1 and hit=0:
  - OUT_VALID <= 0;
  - OUT_DATA, OUT_SEL and ptr hold.
- On a rising edge with ld=0 (FULL with OUT_READY=0): all state holds and every IN_READY bit is 0.
- Drain and refill in the same cycle: this is the FULL & OUT_READY=1 & hit=1 case. It produces back-to-back words with no bubble.
- Wrap-around: when the grant is g=N-1, ptr becomes 0.
- Fairness: a continuously asserted request is granted within N loads.
- Upstream must hold IN_DATA and IN_VALID stable until the handshake completes. The block does not depend on this for correctness, but it does depend on it for fairness.

## Timing
- Reset values (applied on the edge where RST=1):
  - OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, ptr=0.
  - IN_READY=0 in every cycle while RST=1.
- Reset mid-operation discards any held word. No handshake completes in a reset cycle.
- Latency: a word accepted at edge k appears with OUT_VALID=1 after edge k. Downstream can take it at edge k+1 at the earliest.
- OUT_DATA and OUT_SEL are stable while OUT_VALID=1 and OUT_READY=0.
- There are no combinational paths from IN_DATA to any output.
- OUT_READY reaches IN_READY combinationally.

## Configuration
- MUX_FORCE_EN defined:
  - FORCE and FORCE_SEL ports exist.
  - While FORCE=1: hit = IN_VALID[FORCE_SEL] and g = FORCE_SEL. Round-robin is bypassed and ptr holds.
  - While FORCE=0: behaviour is identical to the build without the macro.
- MUX_FORCE_EN undefined:
  - the ports are absent;
  - only round-robin arbitration is used.

## Test plan
- Reset release, no requests: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, IN_READY=0000 for 3 cycles.
- N=4, all IN_VALID=1 with IN_DATA[i]=0xA0+i, OUT_READY=1: OUT_SEL sequence is 0,1,2,3,0,1 on consecutive cycles, OUT_DATA follows it (0xA0…), and there are no bubbles.
- Only channel 2 valid, OUT_READY=1: channel 2 is accepted every cycle and IN_READY=0100 continuously. Then channels 2 and 3 are both valid: the grants alternate 3,2,3 (ptr=3 after the first grant to 2).
- Backpressure: FULL with OUT_SEL=1 and OUT_DATA=0x55, OUT_READY=0 for 5 cycles while channels 0 and 3 are valid: OUT_DATA stays 0x55 and IN_READY=0000. When OUT_READY=1 returns, the next grant is channel 3 (ptr=2).
- RST asserted while FULL with pending requests: the next cycle has OUT_VALID=0 and ptr=0, and the first grant after release goes to the lowest valid index.
- With MUX_FORCE_EN, all channels valid, FORCE=1, FORCE_SEL=2: OUT_SEL=2 every cycle. After FORCE=0 the grants resume from the pointer value held before FORCE was asserted.
